// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between a set of requesters and priority_arbiter.
// The master side (requesters) drives req/done; the slave side (arbiter) returns the grant.
interface priority_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: fixed (highest index wins) or rotating priority.
// A grant is held until the owner signals done or drops its request.
module priority_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned IW          = $clog2(N),
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    priority_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    state_t        state;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic [IW-1:0] ptr;

    logic [IW-1:0] start;
    logic [IW-1:0] win_idx;
    logic          found;
    logic          release_c;
    int unsigned   cand;

    // Downward circular search from the start pointer; first set request wins.
    always_comb begin
        start   = ROUND_ROBIN ? ptr : LAST;
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(start) + N - off) % N;
            if (!found && bus.req[IW'(cand)]) begin
                found   = 1'b1;
                win_idx = IW'(cand);
            end
        end
    end

    // Owner either finishes or withdraws its request.
    assign release_c = bus.done || !bus.req[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= LAST;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= BUSY;
                        grant_q <= ONE << win_idx;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        // Winner drops to lowest priority for the next round.
                        ptr     <= (win_idx == '0) ? LAST : (win_idx - IW'(1));
                    end
                end
                BUSY: begin
                    if (release_c) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: directed vector tables plus random traffic checked
// against a behavioural owner/pointer model, on four configurations in parallel.
module tb_priority_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT 0: N=4 RR, 1: N=4 fixed, 2: N=2 RR, 3: N=16 RR
    logic [15:0] req_v  [4];
    logic        done_v [4];
    logic [15:0] act_g  [4];
    logic [3:0]  act_i  [4];
    logic        act_v  [4];

    priority_arbiter_if #(.N(4))  if0 ();
    priority_arbiter_if #(.N(4))  if1 ();
    priority_arbiter_if #(.N(2))  if2 ();
    priority_arbiter_if #(.N(16)) if3 ();

    assign if0.req = req_v[0][3:0];  assign if0.done = done_v[0];
    assign if1.req = req_v[1][3:0];  assign if1.done = done_v[1];
    assign if2.req = req_v[2][1:0];  assign if2.done = done_v[2];
    assign if3.req = req_v[3];       assign if3.done = done_v[3];

    assign act_g[0] = 16'(if0.grant); assign act_i[0] = 4'(if0.grant_idx); assign act_v[0] = if0.grant_valid;
    assign act_g[1] = 16'(if1.grant); assign act_i[1] = 4'(if1.grant_idx); assign act_v[1] = if1.grant_valid;
    assign act_g[2] = 16'(if2.grant); assign act_i[2] = 4'(if2.grant_idx); assign act_v[2] = if2.grant_valid;
    assign act_g[3] = if3.grant;      assign act_i[3] = if3.grant_idx;      assign act_v[3] = if3.grant_valid;

    priority_arbiter #(.N(4),  .ROUND_ROBIN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    priority_arbiter #(.N(4),  .ROUND_ROBIN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    priority_arbiter #(.N(2),  .ROUND_ROBIN(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    priority_arbiter #(.N(16), .ROUND_ROBIN(1'b1)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int n_of  [4] = '{4, 4, 2, 16};
    bit rr_of [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Behavioural model: current owner (-1 = none) and rotating pointer.
    int m_owner [4];
    int m_ptr   [4];

    int total  = 0;
    int passed = 0;

    // Fairness bookkeeping
    bit fair_on = 1'b0;
    int gcount  [4][16];
    bit prev_v  [4];
    int last_ix [4];

    typedef struct {
        int          d;
        logic        r;
        logic [15:0] rq;
        logic        dn;
        logic [15:0] eg;
        logic [3:0]  ei;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    endtask

    function automatic void model_step(input int d, input logic r, input logic [15:0] rq, input logic dn);
        int n;
        int k;
        n = n_of[d];
        if (r) begin
            m_owner[d] = -1;
            m_ptr[d]   = n - 1;
        end else if (m_owner[d] < 0) begin
            if (rq != 16'h0) begin
                k = rr_of[d] ? m_ptr[d] : n - 1;
                while (!rq[k]) k = (k + n - 1) % n;
                m_owner[d] = k;
                m_ptr[d]   = (k + n - 1) % n;
            end
        end else if (dn || !rq[m_owner[d]]) begin
            m_owner[d] = -1;
        end
    endfunction

    // One clock: advance the model, let the edge pass, compare every DUT.
    task automatic step(input logic r);
        logic [15:0] eg;
        rst = r;
        for (int d = 0; d < 4; d++) model_step(d, r, req_v[d], done_v[d]);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            eg = (m_owner[d] < 0) ? 16'h0 : (16'h1 << m_owner[d]);
            check("model_grant", d, act_g[d], eg);
            check("model_idx",   d, 16'(act_i[d]), (m_owner[d] < 0) ? 16'h0 : 16'(m_owner[d]));
            check("model_valid", d, 16'(act_v[d]), 16'(m_owner[d] >= 0));
            if (fair_on && act_v[d] && !prev_v[d]) begin
                gcount[d][act_i[d]]++;
                check("rr_rotation", d, 16'(act_i[d]), 16'((last_ix[d] + n_of[d] - 1) % n_of[d]));
                last_ix[d] = int'(act_i[d]);
            end
            prev_v[d] = act_v[d];
        end
    endtask

    function automatic void add(input int d, input logic r, input logic [15:0] rq, input logic dn,
                                input logic [15:0] eg, input logic [3:0] ei, input logic ev);
        vec_t v;
        v.d = d; v.r = r; v.rq = rq; v.dn = dn; v.eg = eg; v.ei = ei; v.ev = ev;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            req_v[d] = '0; done_v[d] = 1'b0; m_owner[d] = -1; m_ptr[d] = n_of[d] - 1;
            prev_v[d] = 1'b0; last_ix[d] = 0;
            for (int i = 0; i < 16; i++) gcount[d][i] = 0;
        end

        // Reset, rotation, hold/withdraw and reset mid-grant on N=4 RR
        add(0, 1, 16'hF, 0, 16'h0, 0, 0);
        add(0, 1, 16'hF, 0, 16'h0, 0, 0);
        add(0, 0, 16'hF, 0, 16'h8, 3, 1);
        add(0, 0, 16'hF, 1, 16'h0, 0, 0);
        add(0, 0, 16'hF, 0, 16'h4, 2, 1);
        add(0, 0, 16'hF, 1, 16'h0, 0, 0);
        add(0, 0, 16'hF, 0, 16'h2, 1, 1);
        add(0, 0, 16'hF, 1, 16'h0, 0, 0);
        add(0, 0, 16'hF, 0, 16'h1, 0, 1);
        add(0, 0, 16'hF, 1, 16'h0, 0, 0);
        add(0, 0, 16'hF, 0, 16'h8, 3, 1);
        add(0, 0, 16'hF, 1, 16'h0, 0, 0);
        add(0, 0, 16'h4, 0, 16'h4, 2, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 16'hC, 0, 16'h4, 2, 1);
        add(0, 0, 16'h8, 0, 16'h0, 0, 0);
        add(0, 0, 16'hA, 0, 16'h2, 1, 1);
        add(0, 1, 16'hA, 0, 16'h0, 0, 0);
        add(0, 0, 16'h3, 0, 16'h2, 1, 1);
        add(0, 0, 16'h3, 1, 16'h0, 0, 0);
        add(0, 0, 16'h0, 1, 16'h0, 0, 0);
        add(0, 0, 16'h0, 0, 16'h0, 0, 0);
        // Fixed priority on N=4
        add(1, 1, 16'h0, 0, 16'h0, 0, 0);
        add(1, 0, 16'h6, 0, 16'h4, 2, 1);
        add(1, 0, 16'h6, 1, 16'h0, 0, 0);
        add(1, 0, 16'h3, 0, 16'h2, 1, 1);
        add(1, 0, 16'h3, 1, 16'h0, 0, 0);
        add(1, 0, 16'h1, 0, 16'h1, 0, 1);
        add(1, 0, 16'h1, 1, 16'h0, 0, 0);
        add(1, 0, 16'hF, 0, 16'h8, 3, 1);
        add(1, 0, 16'hF, 1, 16'h0, 0, 0);
        add(1, 0, 16'hF, 0, 16'h8, 3, 1);
        add(1, 0, 16'hF, 1, 16'h0, 0, 0);
        // N=2 rotation
        add(2, 1, 16'h0, 0, 16'h0, 0, 0);
        add(2, 0, 16'h3, 0, 16'h2, 1, 1);
        add(2, 0, 16'h3, 1, 16'h0, 0, 0);
        add(2, 0, 16'h3, 0, 16'h1, 0, 1);
        add(2, 0, 16'h3, 1, 16'h0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int d = 0; d < 4; d++) begin req_v[d] = '0; done_v[d] = 1'b0; end
            req_v[tbl[i].d]  = tbl[i].rq;
            done_v[tbl[i].d] = tbl[i].dn;
            step(tbl[i].r);
            check("tbl_grant", tbl[i].d, act_g[tbl[i].d], tbl[i].eg);
            check("tbl_idx",   tbl[i].d, 16'(act_i[tbl[i].d]), 16'(tbl[i].ei));
            check("tbl_valid", tbl[i].d, 16'(act_v[tbl[i].d]), 16'(tbl[i].ev));
        end

        // Random traffic on all configurations, occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 4; d++) begin
                req_v[d]  = ($urandom_range(0, 3) == 0) ? 16'h0
                          : (16'($urandom) & 16'((32'h1 << n_of[d]) - 1));
                done_v[d] = ($urandom_range(0, 3) == 0);
            end
            step($urandom_range(0, 49) == 0);
        end

        // Fairness with all requesters asserting continuously on N=2 and N=16
        for (int d = 0; d < 4; d++) begin req_v[d] = '0; done_v[d] = 1'b0; end
        step(1'b1);
        for (int d = 0; d < 4; d++) begin prev_v[d] = 1'b0; last_ix[d] = 0; end
        fair_on = 1'b1;
        req_v[2] = 16'h0003;
        req_v[3] = 16'hFFFF;
        for (int c = 0; c < 600; c++) begin
            done_v[2] = $urandom_range(0, 1) == 1;
            done_v[3] = $urandom_range(0, 1) == 1;
            step(1'b0);
        end
        fair_on = 1'b0;
        for (int d = 2; d < 4; d++) begin
            int mn, mx, sum;
            mn = 1 << 30; mx = 0; sum = 0;
            for (int i = 0; i < n_of[d]; i++) begin
                if (gcount[d][i] < mn) mn = gcount[d][i];
                if (gcount[d][i] > mx) mx = gcount[d][i];
                sum += gcount[d][i];
            end
            check("fair_spread", d, 16'(mx - mn <= 1), 16'h1);
            check("fair_volume", d, 16'(sum >= 2 * n_of[d]), 16'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
